// File: rtl/instr_load_arbiter.sv
// Two-requester byte arbiter packing bursts into WIN_BYTES write windows; mem_we one cycle after the completing byte, rdy drops while a stalled window is held.
// Optional INSTR_LOAD_CNT_EN adds a saturating load_byte_cnt output of the bytes written to memory.
module instr_load_arbiter #(
  parameter int WIN_BYTES = 4,
  parameter int LOG_WIN   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_vld,
  input  logic [7:0]             req0_data,
  input  logic                   req0_last,
  output logic                   req0_rdy,
  input  logic                   req1_vld,
  input  logic [7:0]             req1_data,
  input  logic                   req1_last,
  output logic                   req1_rdy,
  input  logic                   mem_stall,
  output logic                   mem_we,
  output logic [LOG_WIN-1:0]     mem_wr_shift_minusone,
  output logic [WIN_BYTES*8-1:0] mem_wr_data,
  output logic                   busy
`ifdef INSTR_LOAD_CNT_EN
  ,
  output logic [15:0]            load_byte_cnt
`endif
);

  localparam int DW = WIN_BYTES * 8;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic [LOG_WIN-1:0] pack_cnt_q, pack_cnt_d;
  logic [DW-1:0]      pack_buf_q, pack_buf_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic [LOG_WIN-1:0] out_shift_q, out_shift_d;
  logic               out_vld_q, out_vld_d;
  logic [DW-1:0]      merged;

  logic       can_take, acc0, acc1, acc, acc_last, complete, drain;
  logic [7:0] acc_data;

  // A held window blocks acceptance only while the memory is stalled.
  assign can_take = ~out_vld_q | ~mem_stall;
  assign req0_rdy = (state_q == GRANT0) & can_take;
  assign req1_rdy = (state_q == GRANT1) & can_take;
  assign acc0     = req0_vld & req0_rdy;
  assign acc1     = req1_vld & req1_rdy;
  assign acc      = acc0 | acc1;
  assign acc_data = acc1 ? req1_data : req0_data;
  assign acc_last = acc1 ? req1_last : req0_last;
  assign complete = acc & (acc_last | (pack_cnt_q == LOG_WIN'(WIN_BYTES - 1)));
  assign drain    = out_vld_q & ~mem_stall;

  assign mem_we                = drain;
  assign mem_wr_data           = out_data_q;
  assign mem_wr_shift_minusone = out_shift_q;
  assign busy                  = (state_q != IDLE) | (pack_cnt_q != '0) | out_vld_q;

  always_comb begin
    merged      = pack_buf_q;
    merged[{pack_cnt_q, 3'b000} +: 8] = acc_data;
    pack_buf_d  = pack_buf_q;
    pack_cnt_d  = pack_cnt_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    if (drain) begin
      out_vld_d   = 1'b0;
      out_data_d  = '0;
      out_shift_d = '0;
    end
    // Pack buffer is kept zero above the fill point, so moved windows have clean unused lanes.
    if (complete) begin
      out_vld_d   = 1'b1;
      out_data_d  = merged;
      out_shift_d = pack_cnt_q;
      pack_buf_d  = '0;
      pack_cnt_d  = '0;
    end else if (acc) begin
      pack_buf_d = merged;
      pack_cnt_d = pack_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_vld && req1_vld) state_q <= last_grant_q ? GRANT0 : GRANT1;
          else if (req0_vld)        state_q <= GRANT0;
          else if (req1_vld)        state_q <= GRANT1;
        end
        GRANT0: if (acc0 && req0_last) begin
          state_q      <= IDLE;
          last_grant_q <= 1'b0;
        end
        GRANT1: if (acc1 && req1_last) begin
          state_q      <= IDLE;
          last_grant_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt_q  <= '0;
      pack_buf_q  <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
    end else begin
      pack_cnt_q  <= pack_cnt_d;
      pack_buf_q  <= pack_buf_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
    end
  end

`ifdef INSTR_LOAD_CNT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;

  assign cnt_sum       = {1'b0, cnt_q} + 17'(out_shift_q) + 17'd1;
  assign load_byte_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (mem_we) cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_instr_load_arbiter.sv
// Scoreboard bench: accepted bytes are chunked into expected windows, a monitor pops them on every mem_we.
module tb_instr_load_arbiter;
  localparam int WB = 4;
  localparam int LW = 2;

  logic clk;
  logic rst_n;
  logic req0_vld, req0_last, req1_vld, req1_last, mem_stall;
  logic [7:0] req0_data, req1_data;
  logic req0_rdy, req1_rdy, mem_we, busy;
  logic [LW-1:0] mem_wr_shift_minusone;
  logic [WB*8-1:0] mem_wr_data;
`ifdef INSTR_LOAD_CNT_EN
  logic [15:0] load_byte_cnt;
  int cnt_model = 0;
`endif

  instr_load_arbiter #(.WIN_BYTES(WB), .LOG_WIN(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_data(req0_data), .req0_last(req0_last), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_data(req1_data), .req1_last(req1_last), .req1_rdy(req1_rdy),
    .mem_stall(mem_stall), .mem_we(mem_we),
    .mem_wr_shift_minusone(mem_wr_shift_minusone), .mem_wr_data(mem_wr_data), .busy(busy)
`ifdef INSTR_LOAD_CNT_EN
    , .load_byte_cnt(load_byte_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; bit l;} item_t;
  typedef struct {logic [31:0] d; logic [1:0] s;} win_t;

  item_t q0[$], q1[$];
  win_t  exp_q[$], obs_log[$];
  logic [7:0] cur[$];
  int start_log[$], gap_log[$];
  int n_cmp = 0, n_err = 0;
  int bubble_pct = 0, stall_pct = 0;
  bit stall_force = 0;
  bit acc0_f = 0, acc1_f = 0;
  bit in_burst = 0;
  int owner = 0, cyc = 0, last_end_cyc = 0, acc_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic win_t make_win();
    win_t w;
    w.d = '0;
    for (int j = 0; j < cur.size(); j++) w.d[j*8 +: 8] = cur[j];
    w.s = 2'(cur.size() - 1);
    return w;
  endfunction

  task automatic accept(input int k, input logic [7:0] d, input bit l);
    if (in_burst) check("burst_owner", k, owner);
    else begin
      start_log.push_back(k);
      gap_log.push_back(cyc - last_end_cyc);
      in_burst = 1;
      owner = k;
    end
    cur.push_back(d);
    acc_total++;
    if (cur.size() == WB || l) begin
      exp_q.push_back(make_win());
      cur.delete();
    end
    if (l) begin
      in_burst = 0;
      last_end_cyc = cyc;
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      win_t w, e;
      check("rdy_exclusive", req0_rdy & req1_rdy, 0);
      acc0_f = req0_vld && req0_rdy;
      acc1_f = req1_vld && req1_rdy;
      if (acc0_f) accept(0, req0_data, req0_last);
      if (acc1_f) accept(1, req1_data, req1_last);
      if (mem_we) begin
        w.d = mem_wr_data;
        w.s = mem_wr_shift_minusone;
        obs_log.push_back(w);
`ifdef INSTR_LOAD_CNT_EN
        cnt_model = cnt_model + int'(w.s) + 1;
        if (cnt_model > 65535) cnt_model = 65535;
`endif
        if (exp_q.size() == 0) check("unexpected_we", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("win_data", w.d, e.d);
          check("win_shift", w.s, e.s);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req0_vld = 0; req1_vld = 0; mem_stall = 0;
      acc0_f = 0; acc1_f = 0;
    end else begin
      if (acc0_f && q0.size() > 0) void'(q0.pop_front());
      if (acc1_f && q1.size() > 0) void'(q1.pop_front());
      acc0_f = 0; acc1_f = 0;
      req0_vld = q0.size() > 0 && ($urandom_range(99) >= bubble_pct);
      if (q0.size() > 0) begin req0_data = q0[0].d; req0_last = q0[0].l; end
      req1_vld = q1.size() > 0 && ($urandom_range(99) >= bubble_pct);
      if (q1.size() > 0) begin req1_data = q1[0].d; req1_last = q1[0].l; end
      mem_stall = stall_force || ($urandom_range(99) < stall_pct);
    end
  end

  task automatic push(input int k, input logic [7:0] d, input bit l);
    item_t it;
    it.d = d; it.l = l;
    if (k == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic push_seq(input int k, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) push(k, first + 8'(i), i == n - 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit done = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      done = q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy;
    end
    check("drain_done", done, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_shift"}, mem_wr_shift_minusone, 0);
    check({tag, "_data"}, mem_wr_data, 0);
    check({tag, "_rdy0"}, req0_rdy, 0);
    check({tag, "_rdy1"}, req1_rdy, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base, pushed, k;
    rst_n = 0; mem_stall = 0;
    req0_vld = 0; req0_data = 0; req0_last = 0;
    req1_vld = 0; req1_data = 0; req1_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #2 rst_n = 1;

    // collision from reset, then a second collision
    push_seq(0, 8'h30, 2); push_seq(1, 8'h40, 2);
    wait_done(100);
    push_seq(0, 8'h50, 2); push_seq(1, 8'h60, 2);
    wait_done(100);
    check("arb_bursts", start_log.size(), 4);
    if (start_log.size() == 4) begin
      check("arb_first", start_log[0], 0);
      check("arb_second", start_log[1], 1);
      check("arb_gap1", gap_log[1], 2);
      check("arb_third", start_log[2], 0);
      check("arb_fourth", start_log[3], 1);
      check("arb_gap3", gap_log[3], 2);
    end

    obs_log.delete();
    push_seq(0, 8'h01, 8);
    wait_done(100);
    check("r0_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      check("r0_w0_data", obs_log[0].d, 32'h04030201);
      check("r0_w0_shift", obs_log[0].s, 3);
      check("r0_w1_data", obs_log[1].d, 32'h08070605);
      check("r0_w1_shift", obs_log[1].s, 3);
    end

    obs_log.delete();
    push_seq(1, 8'hA0, 6);
    wait_done(100);
    check("r1_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      check("r1_w0_data", obs_log[0].d, 32'hA3A2A1A0);
      check("r1_w0_shift", obs_log[0].s, 3);
      check("r1_w1_data", obs_log[1].d, 32'h0000A5A4);
      check("r1_w1_shift", obs_log[1].s, 1);
    end

    // stall held over a completed window
    obs_log.delete();
    stall_force = 1;
    push_seq(0, 8'h11, 8);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_we", mem_we, 0);
      check("stall_data", mem_wr_data, 32'h14131211);
      check("stall_shift", mem_wr_shift_minusone, 3);
      check("stall_rdy0", req0_rdy, 0);
    end
    stall_force = 0;
    @(negedge clk);
    check("release_we", mem_we, 1);
    check("release_data", mem_wr_data, 32'h14131211);
    @(negedge clk);
    check("release_single", mem_we, 0);
    wait_done(100);
    check("stall_count", obs_log.size(), 2);
    if (obs_log.size() == 2) check("stall_w1_data", obs_log[1].d, 32'h18171615);

    // reset after 3 of 4 bytes
    base = acc_total;
    k = 0;
    push_seq(0, 8'h21, 4);
    while (acc_total < base + 3 && k < 50) begin @(negedge clk); k++; end
    check("pre_reset_accepts", acc_total - base, 3);
    @(posedge clk); #2 rst_n = 0;
    q0.delete(); q1.delete(); exp_q.delete(); cur.delete(); obs_log.delete();
    in_burst = 0;
`ifdef INSTR_LOAD_CNT_EN
    cnt_model = 0;
`endif
    @(negedge clk);
    check_zero_outputs("midreset");
    @(posedge clk); #2 rst_n = 1;
    repeat (6) begin @(negedge clk); check("no_we_after_reset", mem_we, 0); end
    push(0, 8'h5A, 1);
    wait_done(50);
    check("one_byte_count", obs_log.size(), 1);
    if (obs_log.size() == 1) begin
      check("one_byte_data", obs_log[0].d, 32'h0000005A);
      check("one_byte_shift", obs_log[0].s, 0);
    end

    // randomized bursts with bubbles and stalls
    bubble_pct = 20; stall_pct = 30;
    base = acc_total;
    pushed = 0;
    for (int b = 0; b < 25; b++) begin
      for (int r = 0; r < 2; r++) begin
        int len = $urandom_range(10, 1);
        for (int i = 0; i < len; i++) push(r, 8'($urandom), i == len - 1);
        pushed += len;
      end
    end
    wait_done(8000);
    bubble_pct = 0; stall_pct = 0;
    check("rand_bytes", acc_total - base, pushed);
    check("rand_leftover_windows", exp_q.size(), 0);
    check("rand_leftover_bytes", cur.size(), 0);
`ifdef INSTR_LOAD_CNT_EN
    @(negedge clk);
    check("load_byte_cnt", load_byte_cnt, cnt_model);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
